// File: rtl/branch_pkg.sv
// Shared types for the branch resolution path: compare codes, funct3 indices,
// the per-stage record and the resolved result record.
package branch_pkg;

    localparam int unsigned BR_XLEN = 32;
    localparam int unsigned F3_W    = 8;

    localparam int unsigned F3_BEQ  = 0;
    localparam int unsigned F3_BNE  = 1;
    localparam int unsigned F3_BLT  = 4;
    localparam int unsigned F3_BGE  = 5;
    localparam int unsigned F3_BLTU = 6;
    localparam int unsigned F3_BGEU = 7;

    typedef enum logic [2:0] {
        CMP_NONE    = 3'd0,
        CMP_EQ      = 3'd1,
        CMP_NE      = 3'd2,
        CMP_LT      = 3'd3,
        CMP_GE      = 3'd4,
        CMP_LTU     = 3'd5,
        CMP_GEU     = 3'd6,
        CMP_ILLEGAL = 3'd7
    } comp_code_t;

    typedef struct packed {
        comp_code_t           comp_code;
        logic                 taken;
        logic [BR_XLEN-1:0]   redirect_pc;
        logic                 mispredict;
        logic                 misaligned;
        logic                 illegal;
    } br_result_t;

    // Decoded/compared record held between decode and target resolution
    typedef struct packed {
        comp_code_t           comp_code;
        logic                 taken;
        logic                 illegal;
        logic                 is_ctl;
        logic                 is_jalr;
        logic                 pred_taken;
        logic [BR_XLEN-1:0]   pc;
        logic [BR_XLEN-1:0]   imm;
        logic [BR_XLEN-1:0]   rs1;
        logic [BR_XLEN-1:0]   pred_target;
    } br_stage0_t;

    // Target, fall-through and prediction check from a decoded record
    function automatic br_result_t br_finalize(input br_stage0_t s);
        br_result_t         r;
        logic [BR_XLEN-1:0] tgt;
        logic [BR_XLEN-1:0] fall;
        if (s.is_jalr) begin
            tgt = (s.rs1 + s.imm) & ~BR_XLEN'(1);
        end else begin
            tgt = s.pc + s.imm;
        end
        fall          = s.pc + BR_XLEN'(4);
        r.comp_code   = s.comp_code;
        r.taken       = s.taken;
        r.illegal     = s.illegal;
        r.redirect_pc = s.taken ? tgt : fall;
        r.mispredict  = !s.illegal &&
                        ((s.taken != s.pred_taken) || (s.taken && (s.pred_target != tgt)));
        r.misaligned  = s.taken && tgt[1];
        return r;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational funct3/flag decode and operand compare for one control-transfer.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [F3_W-1:0] i_decoded_f3,
    input  logic            i_is_branch,
    input  logic            i_is_jal,
    input  logic            i_is_jalr,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output comp_code_t      o_comp_code_c,
    output logic            o_taken_c,
    output logic            o_illegal_c
);

    localparam logic [F3_W-1:0] OH_BEQ  = F3_W'(1) << F3_BEQ;
    localparam logic [F3_W-1:0] OH_BNE  = F3_W'(1) << F3_BNE;
    localparam logic [F3_W-1:0] OH_BLT  = F3_W'(1) << F3_BLT;
    localparam logic [F3_W-1:0] OH_BGE  = F3_W'(1) << F3_BGE;
    localparam logic [F3_W-1:0] OH_BLTU = F3_W'(1) << F3_BLTU;
    localparam logic [F3_W-1:0] OH_BGEU = F3_W'(1) << F3_BGEU;

    logic       w_multi;
    logic       w_eq;
    logic       w_lt_s;
    logic       w_lt_u;
    comp_code_t w_cc_branch;

    assign w_multi = (i_is_branch & i_is_jal) | (i_is_branch & i_is_jalr) | (i_is_jal & i_is_jalr);
    assign w_eq    = (i_rs1 == i_rs2);
    assign w_lt_s  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_lt_u  = (i_rs1 < i_rs2);

    // Exact one-hot match only; reserved, empty or multi-bit patterns fall to illegal
    always_comb begin
        w_cc_branch = CMP_ILLEGAL;
        case (i_decoded_f3)
            OH_BEQ:  w_cc_branch = CMP_EQ;
            OH_BNE:  w_cc_branch = CMP_NE;
            OH_BLT:  w_cc_branch = CMP_LT;
            OH_BGE:  w_cc_branch = CMP_GE;
            OH_BLTU: w_cc_branch = CMP_LTU;
            OH_BGEU: w_cc_branch = CMP_GEU;
            default: w_cc_branch = CMP_ILLEGAL;
        endcase
    end

    always_comb begin
        o_comp_code_c = CMP_NONE;
        o_taken_c     = 1'b0;
        o_illegal_c   = 1'b0;
        if (w_multi) begin
            o_comp_code_c = CMP_ILLEGAL;
            o_illegal_c   = 1'b1;
        end else if (i_is_branch) begin
            o_comp_code_c = w_cc_branch;
            o_illegal_c   = (w_cc_branch == CMP_ILLEGAL);
            case (w_cc_branch)
                CMP_EQ:  o_taken_c = w_eq;
                CMP_NE:  o_taken_c = !w_eq;
                CMP_LT:  o_taken_c = w_lt_s;
                CMP_GE:  o_taken_c = !w_lt_s;
                CMP_LTU: o_taken_c = w_lt_u;
                CMP_GEU: o_taken_c = !w_lt_u;
                default: o_taken_c = 1'b0;
            endcase
        end else if (i_is_jal || i_is_jalr) begin
            o_taken_c = 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch/jump resolution with valid/ready output, prediction check
// and saturating branch/mispredict counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [F3_W-1:0]  decoded_f3,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       comp_code,
    output logic             taken,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             mispredict,
    output logic             misaligned,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    comp_code_t       w_cc;
    logic             w_taken;
    logic             w_illegal;
    br_stage0_t       w_s0_next;
    logic             w_adv_out;

    logic             r_out_valid;
    br_result_t       r_out;
    logic             r_out_ctl;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    branch_cond_eval #(.XLEN(XLEN)) u_cond_eval (
        .i_decoded_f3  (decoded_f3),
        .i_is_branch   (is_branch),
        .i_is_jal      (is_jal),
        .i_is_jalr     (is_jalr),
        .i_rs1         (rs1),
        .i_rs2         (rs2),
        .o_comp_code_c (w_cc),
        .o_taken_c     (w_taken),
        .o_illegal_c   (w_illegal)
    );

    always_comb begin
        w_s0_next             = '0;
        w_s0_next.comp_code   = w_cc;
        w_s0_next.taken       = w_taken;
        w_s0_next.illegal     = w_illegal;
        w_s0_next.is_ctl      = !w_illegal && (is_branch || is_jal || is_jalr);
        w_s0_next.is_jalr     = is_jalr;
        w_s0_next.pred_taken  = pred_taken;
        w_s0_next.pc          = BR_XLEN'(pc);
        w_s0_next.imm         = BR_XLEN'(imm);
        w_s0_next.rs1         = BR_XLEN'(rs1);
        w_s0_next.pred_target = BR_XLEN'(pred_target);
    end

    assign w_adv_out = !r_out_valid || out_ready;

    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            logic       r_s0_valid;
            br_stage0_t r_s0;

            assign in_ready = !r_s0_valid || w_adv_out;

            // Stage 0: decode and compare result
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s0_valid <= 1'b0;
                    r_s0       <= '0;
                end else if (flush) begin
                    r_s0_valid <= 1'b0;
                end else if (in_ready) begin
                    r_s0_valid <= in_valid;
                    if (in_valid) begin
                        r_s0 <= w_s0_next;
                    end
                end
            end

            // Stage 1: target, redirect and prediction check
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_valid <= 1'b0;
                    r_out       <= '0;
                    r_out_ctl   <= 1'b0;
                end else if (flush) begin
                    r_out_valid <= 1'b0;
                end else if (w_adv_out) begin
                    r_out_valid <= r_s0_valid;
                    if (r_s0_valid) begin
                        r_out     <= br_finalize(r_s0);
                        r_out_ctl <= r_s0.is_ctl;
                    end
                end
            end
        end else begin : g_one_stage
            assign in_ready = w_adv_out;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_out_valid <= 1'b0;
                    r_out       <= '0;
                    r_out_ctl   <= 1'b0;
                end else if (flush) begin
                    r_out_valid <= 1'b0;
                end else if (w_adv_out) begin
                    r_out_valid <= in_valid;
                    if (in_valid) begin
                        r_out     <= br_finalize(w_s0_next);
                        r_out_ctl <= w_s0_next.is_ctl;
                    end
                end
            end
        end
    endgenerate

    // Counters advance on each consumed record and stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            if (r_out_ctl && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (r_out.mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign comp_code   = r_out.comp_code;
    assign taken       = r_out.taken;
    assign redirect_pc = XLEN'(r_out.redirect_pc);
    assign mispredict  = r_out.mispredict;
    assign misaligned  = r_out.misaligned;
    assign illegal     = r_out.illegal;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: vector table on a single-stage unit, handshake/flush/reset
// sequences on a two-stage unit.
module tb_branch_resolve_unit;

    typedef struct {
        logic [7:0]  f3;
        logic        b;
        logic        j;
        logic        jr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pt;
        logic [31:0] ptgt;
        logic [2:0]  cc;
        logic        tk;
        logic [31:0] rpc;
        logic        mis;
        logic        mal;
        logic        ill;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  f3;
    logic        b, j, jr, pt;
    logic [31:0] rs1, rs2, pc, imm, ptgt;

    logic        in_valid1, out_ready1, flush1, in_ready1, out_valid1;
    logic        taken1, mispredict1, misaligned1, illegal1;
    logic [2:0]  comp_code1;
    logic [31:0] redirect_pc1;
    logic [15:0] branch_cnt1, mispred_cnt1;

    logic        in_valid2, out_ready2, flush2, in_ready2, out_valid2;
    logic        taken2, mispredict2, misaligned2, illegal2;
    logic [2:0]  comp_code2;
    logic [31:0] redirect_pc2;
    logic [15:0] branch_cnt2, mispred_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve_unit #(.XLEN(32), .PIPE_STAGES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
        .decoded_f3(f3), .is_branch(b), .is_jal(j), .is_jalr(jr), .rs1(rs1), .rs2(rs2),
        .pc(pc), .imm(imm), .pred_taken(pt), .pred_target(ptgt),
        .out_valid(out_valid1), .out_ready(out_ready1), .comp_code(comp_code1), .taken(taken1),
        .redirect_pc(redirect_pc1), .mispredict(mispredict1), .misaligned(misaligned1),
        .illegal(illegal1), .branch_cnt(branch_cnt1), .mispred_cnt(mispred_cnt1)
    );

    branch_resolve_unit #(.XLEN(32), .PIPE_STAGES(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
        .decoded_f3(f3), .is_branch(b), .is_jal(j), .is_jalr(jr), .rs1(rs1), .rs2(rs2),
        .pc(pc), .imm(imm), .pred_taken(pt), .pred_target(ptgt),
        .out_valid(out_valid2), .out_ready(out_ready2), .comp_code(comp_code2), .taken(taken2),
        .redirect_pc(redirect_pc2), .mispredict(mispredict2), .misaligned(misaligned2),
        .illegal(illegal2), .branch_cnt(branch_cnt2), .mispred_cnt(mispred_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        f3 = v.f3; b = v.b; j = v.j; jr = v.jr;
        rs1 = v.rs1; rs2 = v.rs2; pc = v.pc; imm = v.imm;
        pt = v.pt; ptgt = v.ptgt;
    endtask

    // Correctly predicted JAL: target = a_pc + a_imm
    task automatic drive_jal(input logic [31:0] a_pc, input logic [31:0] a_imm);
        f3 = 8'h00; b = 1'b0; j = 1'b1; jr = 1'b0;
        rs1 = 32'h0; rs2 = 32'h0; pc = a_pc; imm = a_imm;
        pt = 1'b1; ptgt = a_pc + a_imm;
    endtask

    vec_t        vecs[15];
    logic [31:0] exp_bc1, exp_mc1, exp_bc2, exp_mc2;
    logic [31:0] exp_seq[4];
    logic [31:0] held_rpc;

    initial begin
        vecs[0]  = '{8'h01, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0,
                     3'd1, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'h10, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b1, 32'h240,
                     3'd3, 1'b1, 32'h240, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h40, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b1, 32'h240,
                     3'd5, 1'b0, 32'h204, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'h04, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'h300, 32'h40, 1'b1, 32'h340,
                     3'd7, 1'b0, 32'h304, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{8'h00, 1'b0, 1'b0, 1'b1, 32'h1001, 32'd0, 32'h400, 32'h2, 1'b1, 32'h1002,
                     3'd0, 1'b1, 32'h1002, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{8'h02, 1'b1, 1'b0, 1'b0, 32'd3, 32'd3, 32'hFFFFFFFC, 32'h8, 1'b0, 32'h0,
                     3'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h20, 1'b1, 1'b0, 1'b0, 32'd1, 32'hFFFFFFFF, 32'h500, 32'hFFFFFFF0, 1'b0, 32'h0,
                     3'd4, 1'b1, 32'h4F0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{8'h80, 1'b1, 1'b0, 1'b0, 32'd1, 32'hFFFFFFFF, 32'h600, 32'h10, 1'b0, 32'h0,
                     3'd6, 1'b0, 32'h604, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'h00, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h700, 32'h100, 1'b1, 32'h900,
                     3'd0, 1'b1, 32'h800, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h800, 32'h10, 1'b1, 32'h810,
                     3'd0, 1'b0, 32'h804, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{8'h01, 1'b1, 1'b1, 1'b0, 32'd7, 32'd7, 32'h900, 32'h10, 1'b1, 32'h910,
                     3'd7, 1'b0, 32'h904, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{8'h00, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'hA00, 32'h10, 1'b0, 32'h0,
                     3'd7, 1'b0, 32'hA04, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{8'h03, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'hB00, 32'h10, 1'b0, 32'h0,
                     3'd7, 1'b0, 32'hB04, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{8'h01, 1'b1, 1'b0, 1'b0, 32'd5, 32'd6, 32'hC00, 32'h20, 1'b0, 32'h0,
                     3'd1, 1'b0, 32'hC04, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{8'h00, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'hD00, 32'h2, 1'b1, 32'hD02,
                     3'd0, 1'b1, 32'hD02, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; flush1 = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; flush2 = 1'b0;
        drive_jal(32'h0, 32'h0);
        exp_bc1 = 0; exp_mc1 = 0; exp_bc2 = 0; exp_mc2 = 0;

        // Reset state
        #12;
        check("rst.out_valid1", 32'(out_valid1), 32'd0);
        check("rst.out_valid2", 32'(out_valid2), 32'd0);
        check("rst.rpc1", redirect_pc1, 32'h0);
        check("rst.bcnt1", 32'(branch_cnt1), 32'd0);
        check("rst.mcnt2", 32'(mispred_cnt2), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready1", 32'(in_ready1), 32'd1);
        check("rst.in_ready2", 32'(in_ready2), 32'd1);

        // Vector table on the single-stage unit
        for (int i = 0; i < 15; i++) begin
            drive_vec(vecs[i]);
            in_valid1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid1 = 1'b0;
            check($sformatf("v%0d.out_valid", i), 32'(out_valid1), 32'd1);
            check($sformatf("v%0d.comp_code", i), 32'(comp_code1), 32'(vecs[i].cc));
            check($sformatf("v%0d.taken", i), 32'(taken1), 32'(vecs[i].tk));
            check($sformatf("v%0d.redirect_pc", i), redirect_pc1, vecs[i].rpc);
            check($sformatf("v%0d.mispredict", i), 32'(mispredict1), 32'(vecs[i].mis));
            check($sformatf("v%0d.misaligned", i), 32'(misaligned1), 32'(vecs[i].mal));
            check($sformatf("v%0d.illegal", i), 32'(illegal1), 32'(vecs[i].ill));
            if (!vecs[i].ill && (vecs[i].b || vecs[i].j || vecs[i].jr)) exp_bc1++;
            if (vecs[i].mis) exp_mc1++;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d.branch_cnt", i), 32'(branch_cnt1), exp_bc1);
            check($sformatf("v%0d.mispred_cnt", i), 32'(mispred_cnt1), exp_mc1);
        end

        // Two-stage latency
        out_ready2 = 1'b1;
        drive_jal(32'h3000, 32'h40);
        in_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        check("lat.out_valid_c1", 32'(out_valid2), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat.out_valid_c2", 32'(out_valid2), 32'd1);
        check("lat.redirect_pc", redirect_pc2, 32'h3040);
        exp_bc2++;
        @(posedge clk);
        @(negedge clk);
        check("lat.branch_cnt", 32'(branch_cnt2), exp_bc2);

        // Back-to-back four records with a three-cycle output stall
        begin
            int sent = 0;
            int got  = 0;
            logic w_rdy, w_ov;
            logic [31:0] w_rpc;
            for (int k = 0; k < 4; k++) exp_seq[k] = 32'h1100 + 32'(k * 16);
            held_rpc = 32'h0;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                out_ready2 = (cyc >= 3);
                in_valid2  = (sent < 4);
                drive_jal(32'h1000 + 32'(sent * 16), 32'h100);
                #1;
                w_rdy = in_ready2; w_ov = out_valid2; w_rpc = redirect_pc2;
                if (cyc == 2) begin
                    check("b2b.accepts_before_stall", 32'(sent), 32'd2);
                    check("b2b.in_ready_stalled", 32'(w_rdy), 32'd0);
                    check("b2b.out_valid_stalled", 32'(w_ov), 32'd1);
                    held_rpc = w_rpc;
                end
                if (cyc == 3) check("b2b.held_stable", w_rpc, held_rpc);
                @(posedge clk);
                if (w_ov && out_ready2) begin
                    check($sformatf("b2b.order%0d", got), w_rpc, exp_seq[got]);
                    got++;
                end
                if (in_valid2 && w_rdy) sent++;
                @(negedge clk);
            end
            in_valid2 = 1'b0;
            check("b2b.records_received", 32'(got), 32'd4);
            exp_bc2 += 4;
            check("b2b.branch_cnt", 32'(branch_cnt2), exp_bc2);
        end

        // Flush with a full pipeline and a concurrent input
        out_ready2 = 1'b0;
        drive_jal(32'h2000, 32'h10);
        in_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_jal(32'h2100, 32'h10);
        @(posedge clk);
        @(negedge clk);
        drive_jal(32'h2200, 32'h10);
        flush2 = 1'b1;
        #1;
        check("flush.full_before", 32'(out_valid2), 32'd1);
        @(posedge clk);
        @(negedge clk);
        flush2 = 1'b0; in_valid2 = 1'b0;
        check("flush.out_valid_next", 32'(out_valid2), 32'd0);
        out_ready2 = 1'b1;
        repeat (3) @(negedge clk);
        check("flush.stays_empty", 32'(out_valid2), 32'd0);
        check("flush.branch_cnt", 32'(branch_cnt2), exp_bc2);
        check("flush.mispred_cnt", 32'(mispred_cnt2), exp_mc2);

        // Flush on an empty pipeline drops the handshaking record
        drive_jal(32'h2400, 32'h10);
        in_valid2 = 1'b1; flush2 = 1'b1;
        #1;
        check("flush.in_ready_empty", 32'(in_ready2), 32'd1);
        @(posedge clk);
        @(negedge clk);
        flush2 = 1'b0; in_valid2 = 1'b0;
        repeat (2) @(negedge clk);
        check("flush.dropped", 32'(out_valid2), 32'd0);
        check("flush.dropped_cnt", 32'(branch_cnt2), exp_bc2);

        // Asynchronous reset while a record is held at the output
        out_ready2 = 1'b0;
        drive_jal(32'h2800, 32'h10);
        in_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mrst.held", 32'(out_valid2), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst.out_valid", 32'(out_valid2), 32'd0);
        check("mrst.redirect_pc", redirect_pc2, 32'h0);
        check("mrst.branch_cnt", 32'(branch_cnt2), 32'd0);
        check("mrst.branch_cnt1", 32'(branch_cnt1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
